hex_display_arbiter: RTL and testbench
======================================

Name: hex_display_arbiter

Overview:
- Time-slice scheduler that shares the 24-bit six-digit HEX display word between NUM_SRC requesters, such as the Nios PIO readback, local counters and status words.
- Each valid source owns the display for DWELL_CYCLES, then ownership rotates round-robin to the next valid source.
- Output disp_data feeds the six per-digit 7-segment decoders, one nibble per digit, digit 0 = bits [3:0].

Parameters:
- NUM_SRC, 4, number of requesters (2..8).
- DATA_W, 24, display word width (6 digits x 4 bits).
- DWELL_CYCLES, 50000000, clk cycles per time slice (1 s at 50 MHz); must be >= 2.
- CNT_W, 26, dwell counter width; must satisfy 2^CNT_W > DWELL_CYCLES.
- OWN_W, 2, owner index width, equal to clog2(NUM_SRC).

Ports:
- clk, in, 1, system clock (50 MHz).
- reset, in, 1, synchronous, active-high reset.
- src_valid, in, NUM_SRC, bit i high = source i requests the display.
- src_data, in, NUM_SRC*DATA_W, source i word at [i*DATA_W +: DATA_W].
- freeze, in, 1, high = pause dwell counting (current owner keeps display).
- src_ack, out, NUM_SRC, one-cycle pulse on bit i when source i is granted.
- disp_data, out, DATA_W, registered display word.
- disp_owner, out, OWN_W, index of current owner.
- disp_active, out, 1, high while a source owns the display.

Behaviour:
- All outputs are registered.
- Reset values:
  - state = IDLE
  - disp_data = 0
  - disp_owner = 0
  - disp_active = 0
  - src_ack = 0
  - dwell_cnt = 0
- Reset mid-slice aborts the slice; no ack is issued on the reset cycle.
- Picker (combinational):
  - Searches src_valid starting at (disp_owner+1) mod NUM_SRC, wrapping, with disp_owner examined last.
  - Returns found flag and index.
  - In IDLE the search starts at (disp_owner+1) as well, so rotation fairness survives idle gaps.
- IDLE state:
  - If found at an edge: owner <= idx, disp_data <= src_data[idx], src_ack[idx] <= 1, dwell_cnt <= 0, disp_active <= 1, go to SHOW.
  - Grant latency is 1 cycle from valid to outputs.
  - Otherwise stay in IDLE; disp_data holds its last value.
- SHOW state, each cycle, evaluated in priority order:
  1. Owner drops src_valid: re-grant via picker in the same edge (same update as IDLE). If nothing is found, go to IDLE with disp_active <= 0 and disp_data held.
  2. dwell_cnt == DWELL_CYCLES-1 and freeze low: re-grant via picker.
     - If only the owner is valid, the picker returns the owner: re-ack pulse, counter restarts.
  3. Otherwise: disp_data <= src_data[owner] (live tracking); dwell_cnt += 1 unless freeze is high.
- freeze does not block re-grant on owner drop.
- src_ack is high for exactly one cycle per grant and is zero on all other cycles; at most one bit is set.
- dwell_cnt never exceeds DWELL_CYCLES-1. No wrap arithmetic is exposed; owner index increment wraps mod NUM_SRC, which also handles non-power-of-two NUM_SRC.
- A simultaneous new request and expiry is resolved by the picker order only; no starvation, since every valid source is granted within NUM_SRC slices.

Decomposition:
- Package hex_disp_pkg holds:
  - the state encoding (IDLE, SHOW)
  - default DATA_W, NUM_SRC, DWELL_CYCLES
  - the digit count constant (6)
- Sub-module rr_pick: purely combinational round-robin picker.
  - Inputs: req vector, last-owner index.
  - Outputs: found, idx.
  - Reusable for other shared-peripheral arbiters.
- Top module: FSM, counter, output registers.

Test Plan (NUM_SRC=4, DWELL_CYCLES=4 in simulation):
1. Reset held for 3 cycles, all valid=0 -> disp_active=0, disp_data=0x000000, src_ack=0; remains IDLE after release.
2. Only src 2 valid with data 0x123456 -> next cycle disp_owner=2, src_ack=4'b0100 for 1 cycle, disp_data=0x123456. After 4 cycles, src_ack pulses 4'b0100 again with no owner change.
3. Sources 0, 1 and 3 valid, owner 0 after the first grant -> grants 0, 1, 3, 0 each 4 cycles apart; disp_data matches each owner's word.
4. Owner 1 drops valid mid-slice at count 1, source 3 valid -> next edge disp_owner=3 and src_ack[3] pulses; owner 1 does not wait out its slice.
5. freeze=1 for 10 cycles during owner 0's slice with source 1 valid -> owner stays 0 for the 10 cycles plus the remaining slice. Owner data change 0xAAAAAA->0x555555 appears on disp_data 1 cycle later.
6. Reset asserted during SHOW -> next edge all outputs return to reset values; re-grant starts from owner index 1 search order.

Source files
------------

// File: rtl/hex_disp_pkg.sv
// Shared definitions for the HEX display arbiter slice.
//   - arbiter state encoding
//   - default geometry of the six-digit display word and the requester count
//   - default dwell time (one second at 50 MHz)
package hex_disp_pkg;

    typedef enum logic {
        IDLE = 1'b0,   // nobody owns the display, disp_data holds its last word
        SHOW = 1'b1    // a source owns the display for a dwell slice
    } disp_state_t;

    localparam int NUM_DIGITS       = 6;
    localparam int DEF_DATA_W       = NUM_DIGITS * 4;
    localparam int DEF_NUM_SRC      = 4;
    localparam int DEF_DWELL_CYCLES = 50_000_000;

endpackage : hex_disp_pkg

// File: rtl/rr_pick.sv
// Combinational round-robin picker.
// Searches req starting at (last+1) mod NUM_SRC, wrapping, so that the
// previous owner is examined last. Usable by any shared-peripheral arbiter.
//   req   : request vector, bit i = requester i wants the resource
//   last  : index of the previous owner
//   found : at least one request bit is set
//   idx   : first requester found in rotation order (last when none found)
module rr_pick #(
    parameter int NUM_SRC = 4,
    parameter int OWN_W   = 2
) (
    input  logic [NUM_SRC-1:0] req,
    input  logic [OWN_W-1:0]   last,
    output logic               found,
    output logic [OWN_W-1:0]   idx
);

    always_comb begin
        int cand;
        found = 1'b0;
        idx   = last;
        cand  = 0;
        // Walk from the farthest offset to the nearest so the nearest
        // requester after 'last' is the final (winning) assignment. The mod
        // keeps the wrap correct for non-power-of-two NUM_SRC.
        for (int k = NUM_SRC; k >= 1; k--) begin
            cand = (int'(last) + k) % NUM_SRC;
            if (req[cand]) begin
                found = 1'b1;
                idx   = OWN_W'(cand);
            end
        end
    end

endmodule : rr_pick

// File: rtl/hex_display_arbiter.sv
// Time-slice scheduler sharing the 24-bit six-digit HEX display word between
// NUM_SRC requesters. Each valid source owns the display for DWELL_CYCLES,
// then ownership rotates round-robin to the next valid source.
//   clk         : system clock
//   reset       : synchronous, active-high reset
//   src_valid   : bit i high = source i requests the display
//   src_data    : source i word at [i*DATA_W +: DATA_W]
//   freeze      : pause dwell counting; current owner keeps the display
//   src_ack     : one-cycle pulse on bit i when source i is granted
//   disp_data   : registered display word, digit 0 = bits [3:0]
//   disp_owner  : index of the current owner
//   disp_active : high while a source owns the display
module hex_display_arbiter
    import hex_disp_pkg::*;
#(
    parameter int NUM_SRC      = DEF_NUM_SRC,
    parameter int DATA_W       = DEF_DATA_W,
    parameter int DWELL_CYCLES = DEF_DWELL_CYCLES,
    parameter int CNT_W        = 26,
    parameter int OWN_W        = 2
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [NUM_SRC-1:0]        src_valid,
    input  logic [NUM_SRC*DATA_W-1:0] src_data,
    input  logic                      freeze,
    output logic [NUM_SRC-1:0]        src_ack,
    output logic [DATA_W-1:0]         disp_data,
    output logic [OWN_W-1:0]          disp_owner,
    output logic                      disp_active
);

    localparam logic [CNT_W-1:0] DWELL_LAST = CNT_W'(DWELL_CYCLES - 1);

    disp_state_t         state_q, state_d;
    logic [OWN_W-1:0]    owner_q, owner_d;
    logic [DATA_W-1:0]   data_q, data_d;
    logic                active_q, active_d;
    logic [NUM_SRC-1:0]  ack_q, ack_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;

    logic                pick_found;
    logic [OWN_W-1:0]    pick_idx;
    logic                regrant;

    logic [DATA_W-1:0]   src_word [NUM_SRC];

    for (genvar g = 0; g < NUM_SRC; g++) begin : g_unpack
        assign src_word[g] = src_data[g*DATA_W +: DATA_W];
    end

    // The search always starts after the last owner, also from IDLE, so
    // rotation fairness survives idle gaps.
    rr_pick #(
        .NUM_SRC (NUM_SRC),
        .OWN_W   (OWN_W)
    ) u_pick (
        .req   (src_valid),
        .last  (owner_q),
        .found (pick_found),
        .idx   (pick_idx)
    );

    always_comb begin
        // NOTE: every signal written here gets a default first; a path that
        // skipped an assignment would otherwise infer a latch.
        state_d  = state_q;
        owner_d  = owner_q;
        data_d   = data_q;
        active_d = active_q;
        ack_d    = '0;
        cnt_d    = cnt_q;
        regrant  = 1'b0;

        unique case (state_q)
            IDLE: regrant = 1'b1;
            SHOW: begin
                if (!src_valid[owner_q]) begin
                    // Owner withdrew: hand over immediately, freeze or not.
                    regrant = 1'b1;
                end else if (cnt_q == DWELL_LAST && !freeze) begin
                    // Slice expired; picker may return the owner itself.
                    regrant = 1'b1;
                end else begin
                    data_d = src_word[owner_q];
                    if (!freeze) begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
            end
            default: ;
        endcase

        if (regrant) begin
            if (pick_found) begin
                state_d  = SHOW;
                owner_d  = pick_idx;
                data_d   = src_word[pick_idx];
                ack_d    = NUM_SRC'(1) << pick_idx;
                cnt_d    = '0;
                active_d = 1'b1;
            end else begin
                // Nobody left: drop to IDLE, last word stays on the digits.
                state_d  = IDLE;
                active_d = 1'b0;
            end
        end
    end

    // NOTE: state uses non-blocking assignments so every flop samples the
    // pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        // NOTE: reset is sampled on the clock edge; all state, including the
        // display word, is cleared so a mid-slice reset aborts cleanly.
        if (reset) begin
            state_q  <= IDLE;
            owner_q  <= '0;
            data_q   <= '0;
            active_q <= 1'b0;
            ack_q    <= '0;
            cnt_q    <= '0;
        end else begin
            state_q  <= state_d;
            owner_q  <= owner_d;
            data_q   <= data_d;
            active_q <= active_d;
            ack_q    <= ack_d;
            cnt_q    <= cnt_d;
        end
    end

    assign src_ack     = ack_q;
    assign disp_data   = data_q;
    assign disp_owner  = owner_q;
    assign disp_active = active_q;

endmodule : hex_display_arbiter

// File: tb/tb_hex_display_arbiter.sv
// Self-checking bench for hex_display_arbiter (NUM_SRC=4, DWELL_CYCLES=4).
// A slice-level model predicts every output each cycle; directed steps add
// hand-computed literal expectations.
module tb_hex_display_arbiter;

    localparam int NS = 4;
    localparam int DW = 24;
    localparam int DWELL = 4;

    logic            clk;
    logic            reset;
    logic [NS-1:0]   src_valid;
    logic [NS*DW-1:0] src_data;
    logic            freeze;
    logic [NS-1:0]   src_ack;
    logic [DW-1:0]   disp_data;
    logic [1:0]      disp_owner;
    logic            disp_active;

    logic [DW-1:0]   src_w [NS];

    int total = 0;
    int bad   = 0;

    hex_display_arbiter #(
        .NUM_SRC      (NS),
        .DATA_W       (DW),
        .DWELL_CYCLES (DWELL),
        .CNT_W        (3),
        .OWN_W        (2)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .src_valid   (src_valid),
        .src_data    (src_data),
        .freeze      (freeze),
        .src_ack     (src_ack),
        .disp_data   (disp_data),
        .disp_owner  (disp_owner),
        .disp_active (disp_active)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always_comb begin
        src_data = '0;
        for (int i = 0; i < NS; i++) src_data[i*DW +: DW] = src_w[i];
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- slice-level model ----------------
    // A source holds the display for DWELL cycles of unfrozen time; it loses
    // it early only by withdrawing. Successor = first valid after the owner.
    logic          m_active;
    int            m_owner;
    logic [DW-1:0] m_data;
    logic [NS-1:0] m_ack;
    int            m_age;

    function automatic int next_holder(input logic [NS-1:0] v, input int last);
        for (int k = 1; k <= NS; k++)
            if (v[(last + k) % NS]) return (last + k) % NS;
        return -1;
    endfunction

    always @(posedge clk) begin
        int nxt;
        if (reset) begin
            m_active <= 1'b0;
            m_owner  <= 0;
            m_data   <= '0;
            m_ack    <= '0;
            m_age    <= 0;
        end else if (!m_active || !src_valid[m_owner] || (m_age == DWELL - 1 && !freeze)) begin
            nxt = next_holder(src_valid, m_owner);
            if (nxt >= 0) begin
                m_active <= 1'b1;
                m_owner  <= nxt;
                m_data   <= src_w[nxt];
                m_ack    <= NS'(1 << nxt);
                m_age    <= 0;
            end else begin
                m_active <= 1'b0;
                m_ack    <= '0;
            end
        end else begin
            m_ack  <= '0;
            m_data <= src_w[m_owner];
            if (!freeze) m_age <= m_age + 1;
        end
    end

    // One compare process: every cycle, at the falling edge.
    initial begin
        @(posedge clk);
        forever begin
            @(negedge clk);
            check("cmp_active", 32'(disp_active), 32'(m_active));
            check("cmp_owner",  32'(disp_owner),  32'(m_owner));
            check("cmp_data",   32'(disp_data),   32'(m_data));
            check("cmp_ack",    32'(src_ack),     32'(m_ack));
        end
    end

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    initial begin
        reset     = 1'b1;
        src_valid = '0;
        freeze    = 1'b0;
        for (int i = 0; i < NS; i++) src_w[i] = '0;

        // 1: reset with nothing valid, then stay idle.
        step(3);
        check("rst_active", 32'(disp_active), 32'd0);
        check("rst_data",   32'(disp_data),   32'h000000);
        check("rst_ack",    32'(src_ack),     32'd0);
        reset = 1'b0;
        step(2);
        check("idle_active", 32'(disp_active), 32'd0);

        // 2: single source, self re-grant on expiry.
        src_w[2]  = 24'h123456;
        src_valid = 4'b0100;
        step(1);
        check("g2_owner", 32'(disp_owner), 32'd2);
        check("g2_ack",   32'(src_ack),    32'b0100);
        check("g2_data",  32'(disp_data),  32'h123456);
        step(1);
        check("g2_ack_off", 32'(src_ack), 32'd0);
        step(3);
        check("g2_reack", 32'(src_ack),    32'b0100);
        check("g2_same",  32'(disp_owner), 32'd2);

        // 3: rotation 0 -> 1 -> 3 -> 0.
        reset = 1'b1;
        step(1);
        reset = 1'b0;
        src_w[0] = 24'h000AAA;
        src_w[1] = 24'h111111;
        src_w[3] = 24'h333333;
        src_valid = 4'b0001;
        step(1);
        check("r_own0", 32'(disp_owner), 32'd0);
        src_valid = 4'b1011;
        step(4);
        check("r_own1", 32'(disp_owner), 32'd1);
        check("r_ack1", 32'(src_ack),    32'b0010);
        check("r_dat1", 32'(disp_data),  32'h111111);
        step(4);
        check("r_own3", 32'(disp_owner), 32'd3);
        check("r_ack3", 32'(src_ack),    32'b1000);
        check("r_dat3", 32'(disp_data),  32'h333333);
        step(4);
        check("r_own0b", 32'(disp_owner), 32'd0);
        check("r_ack0",  32'(src_ack),    32'b0001);
        check("r_dat0",  32'(disp_data),  32'h000AAA);

        // 4: owner 1 withdraws at count 1.
        step(4);
        check("d_own1", 32'(disp_owner), 32'd1);
        step(1);
        src_valid = 4'b1001;
        step(1);
        check("d_own3", 32'(disp_owner), 32'd3);
        check("d_ack3", 32'(src_ack),    32'b1000);

        // 5: freeze during owner 0's slice, source 1 waiting.
        src_w[0]  = 24'hAAAAAA;
        src_valid = 4'b0011;
        step(1);
        check("f_own0", 32'(disp_owner), 32'd0);
        check("f_dat0", 32'(disp_data),  32'hAAAAAA);
        freeze = 1'b1;
        step(5);
        src_w[0] = 24'h555555;
        step(1);
        check("f_track", 32'(disp_data), 32'h555555);
        step(4);
        check("f_hold", 32'(disp_owner), 32'd0);
        freeze = 1'b0;
        step(3);
        check("f_rest",   32'(disp_owner), 32'd0);
        check("f_noack",  32'(src_ack),    32'd0);
        step(1);
        check("f_own1", 32'(disp_owner), 32'd1);
        check("f_ack1", 32'(src_ack),    32'b0010);

        // 6: reset mid-slice, then rotation restarts searching from 1.
        step(1);
        reset = 1'b1;
        step(1);
        check("mr_active", 32'(disp_active), 32'd0);
        check("mr_data",   32'(disp_data),   32'd0);
        check("mr_owner",  32'(disp_owner),  32'd0);
        check("mr_ack",    32'(src_ack),     32'd0);
        reset = 1'b0;
        step(1);
        check("mr_own1", 32'(disp_owner), 32'd1);
        check("mr_ack1", 32'(src_ack),    32'b0010);

        // Owner drop overrides freeze; then everything withdraws.
        freeze    = 1'b1;
        src_valid = 4'b0001;
        step(1);
        check("fd_own0", 32'(disp_owner), 32'd0);
        check("fd_ack0", 32'(src_ack),    32'b0001);
        src_valid = 4'b0000;
        step(1);
        check("off_active", 32'(disp_active), 32'd0);
        check("off_data",   32'(disp_data),   32'h555555);
        check("off_ack",    32'(src_ack),     32'd0);
        freeze = 1'b0;
        step(2);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule : tb_hex_display_arbiter
